// File: rtl/sd_resp_rx_pkg.sv
// Shared definitions for the SD command-response receiver: FSM states,
// token lengths and the CRC7 polynomial with its serial update step.
package sd_resp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    CHECK      = 2'd3
  } state_e;

  localparam int RESP_LEN_SHORT = 48;
  localparam int RESP_LEN_LONG  = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial step of x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 accumulator; clear together with en restarts the CRC from
// zero using the current bit, so the first covered bit needs no extra cycle.
module sd_crc7_serial
  import sd_resp_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      crc_d = crc7_step(clear ? 7'h00 : crc_q, din);
    end else if (clear) begin
      crc_d = 7'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= 7'h00;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits (bounded) for a start bit, shifts in a
// 48- or 136-bit token, then checks transmission bit, end bit and CRC7.
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         rx_en,
  input  logic         resp_long,
  input  logic         crc_check,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         resp_valid,
  output logic [135:0] resp_data,
  output logic         timeout,
  output logic         crc_err,
  output logic         tx_err,
  output logic         end_err,
  output state_e       dbg_state
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  state_e         state_q, state_d;
  logic           long_q, long_d;
  logic           chk_q, chk_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [135:0]   shreg_q, shreg_d;
  logic [135:0]   resp_data_q, resp_data_d;
  logic           resp_valid_q, resp_valid_d;
  logic           timeout_q, timeout_d;
  logic           crc_err_q, crc_err_d;
  logic           tx_err_q, tx_err_d;
  logic           end_err_q, end_err_d;

  logic       shift;
  logic       crc_arm_clr;
  logic       crc_en;
  logic       crc_clr;
  logic [7:0] bit_num;
  logic [7:0] len;
  logic [7:0] crc_first;
  logic [7:0] crc_last;
  logic [6:0] crc;

  // bit_num is the 1-based index of the bit sampled this cycle.
  assign bit_num   = bcnt_q + 8'd1;
  assign len       = long_q ? 8'(RESP_LEN_LONG) : 8'(RESP_LEN_SHORT);
  assign crc_first = long_q ? 8'd9   : 8'd1;
  assign crc_last  = long_q ? 8'd128 : 8'd40;

  always_comb begin
    state_d      = state_q;
    long_d       = long_q;
    chk_d        = chk_q;
    bcnt_d       = bcnt_q;
    tcnt_d       = tcnt_q;
    shreg_d      = shreg_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    timeout_d    = timeout_q;
    crc_err_d    = crc_err_q;
    tx_err_d     = tx_err_q;
    end_err_d    = end_err_q;
    shift        = 1'b0;
    crc_arm_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_en) begin
          state_d     = WAIT_START;
          long_d      = resp_long;
          chk_d       = crc_check;
          bcnt_d      = 8'd0;
          tcnt_d      = '0;
          shreg_d     = '0;
          timeout_d   = 1'b0;
          crc_err_d   = 1'b0;
          tx_err_d    = 1'b0;
          end_err_d   = 1'b0;
          crc_arm_clr = 1'b1;
        end
      end
      WAIT_START: begin
        if (!sd_cmd) begin
          shift   = 1'b1;
          shreg_d = {shreg_q[134:0], sd_cmd};
          bcnt_d  = 8'd1;
          state_d = RECV;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
          if (tcnt_d == TCW'(TIMEOUT_CYCLES)) begin
            timeout_d    = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      RECV: begin
        shift   = 1'b1;
        shreg_d = {shreg_q[134:0], sd_cmd};
        bcnt_d  = bit_num;
        // Results are registered on the end-bit edge so they appear with the pulse.
        if (bit_num == len) begin
          state_d      = CHECK;
          resp_valid_d = 1'b1;
          resp_data_d  = shreg_d;
          tx_err_d     = long_q ? shreg_d[134] : shreg_d[46];
          end_err_d    = ~shreg_d[0];
          crc_err_d    = chk_q && (crc != shreg_d[7:1]);
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign crc_en  = shift && (bit_num >= crc_first) && (bit_num <= crc_last);
  assign crc_clr = crc_arm_clr || (crc_en && (bit_num == crc_first));

  sd_crc7_serial u_crc (
    .clk   (sd_clk),
    .reset (reset),
    .clear (crc_clr),
    .en    (crc_en),
    .din   (sd_cmd),
    .crc   (crc)
  );

  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      long_q       <= 1'b0;
      chk_q        <= 1'b0;
      bcnt_q       <= 8'd0;
      tcnt_q       <= '0;
      shreg_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      tx_err_q     <= 1'b0;
      end_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      long_q       <= long_d;
      chk_q        <= chk_d;
      bcnt_q       <= bcnt_d;
      tcnt_q       <= tcnt_d;
      shreg_q      <= shreg_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      timeout_q    <= timeout_d;
      crc_err_q    <= crc_err_d;
      tx_err_q     <= tx_err_d;
      end_err_q    <= end_err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign timeout    = timeout_q;
  assign crc_err    = crc_err_q;
  assign tx_err     = tx_err_q;
  assign end_err    = end_err_q;
  assign dbg_state  = state_q;

endmodule
